// File: rtl/misaligned_lsu_if.sv
// rtl/misaligned_lsu_if.sv - MEM-stage request and data-memory port bundle for misaligned_lsu
interface misaligned_lsu_if;
  logic        memreadM_in;
  logic        memwriteM_in;
  logic [31:0] aluAddress_in;
  logic [31:0] DataWriteM_in;
  logic [2:0]  func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;
  logic [31:0] load_data_out;
  logic        stall_out;
  logic        misalign_exc_out;

  modport master (
    output memreadM_in, memwriteM_in, aluAddress_in, DataWriteM_in, func3, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_func3, load_data_out, stall_out, misalign_exc_out
  );

  modport slave (
    input  memreadM_in, memwriteM_in, aluAddress_in, DataWriteM_in, func3, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_func3, load_data_out, stall_out, misalign_exc_out
  );
endinterface

// File: rtl/misaligned_lsu.sv
// rtl/misaligned_lsu.sv - MEM-stage load/store sequencer that splits misaligned accesses into byte ops
module misaligned_lsu #(
  parameter bit SPLIT_EN = 1'b1
) (
  input logic             clk,
  input logic             reset,
  misaligned_lsu_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  logic [0:0]  state;
  logic [1:0]  byte_idx;
  logic [23:0] acc;

  logic        request;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        split_active;
  logic        is_last;
  logic        sign_bit;
  logic [1:0]  cur_idx;
  logic [1:0]  last_idx;
  logic [7:0]  wr_byte;
  logic [31:0] assembled;

  assign request  = bus.memreadM_in | bus.memwriteM_in;
  assign is_half  = (bus.func3 == 3'b001) || (bus.func3 == 3'b101);
  assign is_word  = (bus.func3 == 3'b010);
  assign mis      = (is_half && bus.aluAddress_in[0]) ||
                    (is_word && (bus.aluAddress_in[1:0] != 2'b00));
  // Reset forces pass-through so the pipeline is released in the same cycle it is asserted.
  assign split_active = SPLIT_EN && !reset && ((state == SPLIT) || (request && mis));
  assign cur_idx  = (state == SPLIT) ? byte_idx : 2'd0;
  assign last_idx = is_word ? 2'd3 : 2'd1;
  assign is_last  = (cur_idx == last_idx);
  assign sign_bit = !bus.func3[2] && bus.mem_rdata[7];

  always_comb begin
    wr_byte = bus.DataWriteM_in[7:0];
    case (cur_idx)
      2'd1:    wr_byte = bus.DataWriteM_in[15:8];
      2'd2:    wr_byte = bus.DataWriteM_in[23:16];
      2'd3:    wr_byte = bus.DataWriteM_in[31:24];
      default: wr_byte = bus.DataWriteM_in[7:0];
    endcase
  end

  assign assembled = is_word ? {bus.mem_rdata[7:0], acc}
                             : {{16{sign_bit}}, bus.mem_rdata[7:0], acc[7:0]};

  always_comb begin
    bus.mem_addr      = bus.aluAddress_in;
    bus.mem_wdata     = bus.DataWriteM_in;
    bus.mem_we        = bus.memwriteM_in;
    bus.mem_func3     = bus.func3;
    bus.load_data_out = bus.mem_rdata;
    bus.stall_out     = 1'b0;
    if (split_active) begin
      bus.mem_addr      = bus.aluAddress_in + {30'd0, cur_idx};
      bus.mem_wdata     = {24'd0, wr_byte};
      bus.mem_func3     = bus.memwriteM_in ? 3'b000 : 3'b100;
      bus.load_data_out = assembled;
      bus.stall_out     = !is_last;
    end
  end

  assign bus.misalign_exc_out = mis && request && !SPLIT_EN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      acc      <= 24'd0;
    end else if (split_active) begin
      if (is_last) begin
        state    <= IDLE;
        byte_idx <= 2'd0;
        acc      <= 24'd0;
      end else begin
        state    <= SPLIT;
        byte_idx <= cur_idx + 2'd1;
        case (cur_idx)
          2'd0:    acc[7:0]   <= bus.mem_rdata[7:0];
          2'd1:    acc[15:8]  <= bus.mem_rdata[7:0];
          default: acc[23:16] <= bus.mem_rdata[7:0];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_misaligned_lsu.sv
// tb/tb_misaligned_lsu.sv - directed vector bench for misaligned_lsu with a byte-array data memory
module tb_misaligned_lsu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  misaligned_lsu_if bus();
  misaligned_lsu_if b0();

  misaligned_lsu #(.SPLIT_EN(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  misaligned_lsu #(.SPLIT_EN(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:255];
  logic        mem_clr = 1'b1;
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'd0;
  logic [31:0] pre_word = 32'd0;
  logic [7:0]  rb0, rb1, rb2, rb3;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (pre_en) begin
      for (int i = 0; i < 4; i++) mem[pre_addr[7:0] + 8'(i)] <= pre_word[8*i +: 8];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_func3[1:0] != 2'b00) mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_func3[1:0] == 2'b10) begin
        mem[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wdata[23:16];
        mem[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    rb0 = mem[bus.mem_addr[7:0]];
    rb1 = mem[bus.mem_addr[7:0] + 8'd1];
    rb2 = mem[bus.mem_addr[7:0] + 8'd2];
    rb3 = mem[bus.mem_addr[7:0] + 8'd3];
    case (bus.mem_func3)
      3'b000:  bus.mem_rdata = {{24{rb0[7]}}, rb0};
      3'b100:  bus.mem_rdata = {24'd0, rb0};
      3'b001:  bus.mem_rdata = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  bus.mem_rdata = {16'd0, rb1, rb0};
      default: bus.mem_rdata = {rb3, rb2, rb1, rb0};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pre_addr = a;
    pre_word = w;
    pre_en = 1'b1;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;
    logic        chk_load;
    logic [31:0] exp_load;
    logic        pre;
    logic [31:0] pre_word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input int n,
                              input logic chk, input logic [31:0] exp_load,
                              input logic pre, input logic [31:0] pw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.n = n;
    v.chk_load = chk; v.exp_load = exp_load; v.pre = pre; v.pre_word = pw;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] wexp;
    if (v.pre) preload(v.addr, v.pre_word);
    bus.memreadM_in   = v.rd;
    bus.memwriteM_in  = v.wr;
    bus.func3         = v.f3;
    bus.aluAddress_in = v.addr;
    bus.DataWriteM_in = v.wdata;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      check($sformatf("v%0d.k%0d mem_addr", idx, k), bus.mem_addr, v.addr + 32'(k));
      check($sformatf("v%0d.k%0d stall", idx, k), {31'd0, bus.stall_out}, {31'd0, k != v.n - 1});
      check($sformatf("v%0d.k%0d mem_func3", idx, k), {29'd0, bus.mem_func3},
            {29'd0, (v.n == 1) ? v.f3 : (v.wr ? 3'b000 : 3'b100)});
      check($sformatf("v%0d.k%0d mem_we", idx, k), {31'd0, bus.mem_we}, {31'd0, v.wr});
      check($sformatf("v%0d.k%0d exc", idx, k), {31'd0, bus.misalign_exc_out}, 32'd0);
      if (v.wr) begin
        wexp = (v.n == 1) ? v.wdata : ((v.wdata >> (8 * k)) & 32'hFF);
        check($sformatf("v%0d.k%0d mem_wdata", idx, k), bus.mem_wdata, wexp);
      end
      if (v.chk_load && k == v.n - 1)
        check($sformatf("v%0d load_data", idx), bus.load_data_out, v.exp_load);
      @(posedge clk);
      #1;
    end
    bus.memreadM_in  = 1'b0;
    bus.memwriteM_in = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle stall", idx), {31'd0, bus.stall_out}, 32'd0);
    check($sformatf("v%0d idle we", idx), {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.memreadM_in = 1'b0; bus.memwriteM_in = 1'b0; bus.func3 = 3'b010;
    bus.aluAddress_in = 32'd0; bus.DataWriteM_in = 32'd0;
    b0.memreadM_in = 1'b0; b0.memwriteM_in = 1'b0; b0.func3 = 3'b010;
    b0.aluAddress_in = 32'd0; b0.DataWriteM_in = 32'd0; b0.mem_rdata = 32'hCAFEF00D;

    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 0, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h11, 0, 4, 1, 32'h04030201, 1, 32'h04030201));
    vecs.push_back(mk(1, 0, 3'b001, 32'h23, 0, 2, 1, 32'hFFFF9234, 1, 32'h00009234));
    vecs.push_back(mk(1, 0, 3'b101, 32'h23, 0, 2, 1, 32'h00009234, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h2E, 32'hA1B2C3D4, 4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h2C, 0, 1, 1, 32'hC3D40000, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h30, 0, 1, 1, 32'h0000A1B2, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'hFFFFFFFF, 0, 4, 1, 32'h88776655, 1, 32'h88776655));
    vecs.push_back(mk(0, 1, 3'b001, 32'h41, 32'h1234BEEF, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h41, 0, 2, 1, 32'h0000BEEF, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h41, 0, 2, 1, 32'hFFFFBEEF, 0, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h41, 0, 1, 1, 32'hFFFFFFEF, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h42, 0, 4, 1, 32'h000000BE, 0, 0));
    vecs.push_back(mk(1, 0, 3'b110, 32'h13, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h4A, 32'h55667788, 4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h48, 0, 1, 1, 32'h77880000, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h4C, 0, 1, 1, 32'h00005566, 0, 0));

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("reset stall", {31'd0, bus.stall_out}, 32'd0);
    check("reset we", {31'd0, bus.mem_we}, 32'd0);
    check("reset exc", {31'd0, b0.misalign_exc_out}, 32'd0);
    check("reset state", {31'd0, u_dut.state}, 32'd0);
    check("reset acc", {8'd0, u_dut.acc}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset in cycle 2 of a misaligned LW
    preload(32'h51, 32'h0A0B0C0D);
    bus.memreadM_in = 1'b1; bus.func3 = 3'b010; bus.aluAddress_in = 32'h51;
    @(negedge clk);
    check("rst k0 stall", {31'd0, bus.stall_out}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst k1 addr", bus.mem_addr, 32'h52);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst k2 addr", bus.mem_addr, 32'h53);
    check("rst k2 stall", {31'd0, bus.stall_out}, 32'd1);
    check("rst k2 acc", {16'd0, u_dut.acc[15:0]}, 32'h00000C0D);
    #1 reset = 1'b1;
    #1;
    check("rst stall", {31'd0, bus.stall_out}, 32'd0);
    check("rst state", {31'd0, u_dut.state}, 32'd0);
    check("rst acc", {8'd0, u_dut.acc}, 32'd0);
    check("rst addr", bus.mem_addr, 32'h51);
    bus.memreadM_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    preload(32'h60, 32'h12345678);
    bus.memreadM_in = 1'b1; bus.func3 = 3'b010; bus.aluAddress_in = 32'h60;
    @(negedge clk);
    check("post-rst load", bus.load_data_out, 32'h12345678);
    check("post-rst stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk); #1;
    bus.memreadM_in = 1'b0;

    // SPLIT_EN=0 instance flags instead of splitting
    b0.memreadM_in = 1'b1; b0.func3 = 3'b001; b0.aluAddress_in = 32'h5;
    @(negedge clk);
    check("nosplit exc", {31'd0, b0.misalign_exc_out}, 32'd1);
    check("nosplit addr", b0.mem_addr, 32'h5);
    check("nosplit f3", {29'd0, b0.mem_func3}, 32'd1);
    check("nosplit stall", {31'd0, b0.stall_out}, 32'd0);
    check("nosplit load", b0.load_data_out, 32'hCAFEF00D);
    @(posedge clk); #1;
    b0.aluAddress_in = 32'h4;
    @(negedge clk);
    check("nosplit aligned exc", {31'd0, b0.misalign_exc_out}, 32'd0);
    @(posedge clk); #1;
    b0.memreadM_in = 1'b0; b0.memwriteM_in = 1'b1; b0.func3 = 3'b010;
    b0.aluAddress_in = 32'h6; b0.DataWriteM_in = 32'h11223344;
    @(negedge clk);
    check("nosplit sw exc", {31'd0, b0.misalign_exc_out}, 32'd1);
    check("nosplit sw we", {31'd0, b0.mem_we}, 32'd1);
    check("nosplit sw wdata", b0.mem_wdata, 32'h11223344);
    @(posedge clk); #1;
    b0.memwriteM_in = 1'b0;
    @(negedge clk);
    check("nosplit idle exc", {31'd0, b0.misalign_exc_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
